dfp_burst_adapter: RTL and testbench

//  Memory-side responder for the cache dfp port (256-bit line read/write, dfp_resp handshake).

---
 rtl/dfp_burst_adapter.sv | 155 +++++++++++++++
 tb/tb_dfp_burst_adapter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dfp_burst_adapter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dfp_burst_adapter: cache dfp line port <-> BURST_LEN-beat bmem bursts.   |
// | Optional PROTOCOL_CHECK_EN: sticky proto_err plus simulation $error.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module dfp_burst_adapter #(
  parameter int BEAT_W    = 64,
  parameter int BURST_LEN = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [31:0]                 dfp_addr,
  input  logic                        dfp_read,
  input  logic                        dfp_write,
  input  logic [BEAT_W*BURST_LEN-1:0] dfp_wdata,
  output logic [BEAT_W*BURST_LEN-1:0] dfp_rdata,
  output logic                        dfp_resp,
  output logic [31:0]                 bmem_addr,
  output logic                        bmem_read,
  output logic                        bmem_write,
  output logic [BEAT_W-1:0]           bmem_wdata,
  input  logic                        bmem_ready,
  input  logic [31:0]                 bmem_raddr,
  input  logic [BEAT_W-1:0]           bmem_rdata,
  input  logic                        bmem_rvalid,
  output logic                        proto_err
);

  localparam int              LINE_W    = BEAT_W * BURST_LEN;
  localparam int              CNT_W     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);
  localparam logic [31:0]     OFS_MASK  = 32'(LINE_W / 8 - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_CMD  = 3'd1,
    RD_DATA = 3'd2,
    WR_DATA = 3'd3,
    RESP    = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  beat_cnt, beat_cnt_nxt;
  logic [31:0]       line_addr;
  logic [LINE_W-1:0] line_buf;
  logic [LINE_W-1:0] line_merged;

  // line_buf holds the write line during a write and the partial read line during a read
  always_comb begin
    line_merged = line_buf;
    line_merged[beat_cnt*BEAT_W +: BEAT_W] = bmem_rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      beat_cnt  <= '0;
      line_addr <= '0;
      line_buf  <= '0;
      dfp_rdata <= '0;
    end else begin
      state    <= state_nxt;
      beat_cnt <= beat_cnt_nxt;
      if (state == IDLE && (dfp_read || dfp_write)) begin
        line_addr <= dfp_addr & ~OFS_MASK;
        if (dfp_write) line_buf <= dfp_wdata;
      end
      if (state == RD_DATA && bmem_rvalid) begin
        line_buf <= line_merged;
        if (beat_cnt == LAST_BEAT) dfp_rdata <= line_merged;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    beat_cnt_nxt = beat_cnt;
    bmem_read    = 1'b0;
    bmem_write   = 1'b0;
    bmem_addr    = '0;
    bmem_wdata   = '0;
    dfp_resp     = 1'b0;
    case (state)
      IDLE: begin
        beat_cnt_nxt = '0;
        // a pending writeback goes first; the held read is picked up after its RESP
        if (dfp_write)     state_nxt = WR_DATA;
        else if (dfp_read) state_nxt = RD_CMD;
      end
      RD_CMD: begin
        bmem_read = 1'b1;
        bmem_addr = line_addr;
        if (bmem_ready) begin
          state_nxt    = RD_DATA;
          beat_cnt_nxt = '0;
        end
      end
      RD_DATA: begin
        if (bmem_rvalid) begin
          beat_cnt_nxt = beat_cnt + CNT_W'(1);
          if (beat_cnt == LAST_BEAT) state_nxt = RESP;
        end
      end
      WR_DATA: begin
        bmem_write = 1'b1;
        bmem_addr  = line_addr;
        bmem_wdata = line_buf[beat_cnt*BEAT_W +: BEAT_W];
        if (bmem_ready) begin
          beat_cnt_nxt = beat_cnt + CNT_W'(1);
          if (beat_cnt == LAST_BEAT) state_nxt = RESP;
        end
      end
      RESP: begin
        dfp_resp  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef PROTOCOL_CHECK_EN
  logic ev_rvalid_outside, ev_raddr_bad, ev_both_req, ev_addr_chg, proto_ev, proto_err_r;

  always_comb begin
    ev_rvalid_outside = bmem_rvalid && (state != RD_DATA);
    ev_raddr_bad      = bmem_rvalid && (state == RD_DATA) && (bmem_raddr != line_addr);
    ev_both_req       = (state == IDLE) && dfp_read && dfp_write;
    ev_addr_chg       = (state != IDLE) && (dfp_read || dfp_write) &&
                        ((dfp_addr & ~OFS_MASK) != line_addr);
    proto_ev          = ev_rvalid_outside | ev_raddr_bad | ev_both_req | ev_addr_chg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        proto_err_r <= 1'b0;
    else if (proto_ev) proto_err_r <= 1'b1;
  end

  assign proto_err = proto_err_r;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst_n && proto_ev)
      $error("dfp_burst_adapter protocol event: rvalid_outside=%0b raddr=%0b both=%0b addr_chg=%0b",
             ev_rvalid_outside, ev_raddr_bad, ev_both_req, ev_addr_chg);
  end
`endif
`else
  logic unused_raddr;
  assign unused_raddr = ^bmem_raddr;
  assign proto_err    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dfp_burst_adapter.sv
`default_nettype none
// tb_dfp_burst_adapter: directed vector table, hand sequences and randomized
// transactions checked against a transaction-level model of the adapter.
module tb_dfp_burst_adapter;

  localparam int MAXC = 160;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  dfp_addr;
  logic         dfp_read, dfp_write;
  logic [255:0] dfp_wdata, dfp_rdata;
  logic         dfp_resp;
  logic [31:0]  bmem_addr;
  logic         bmem_read, bmem_write;
  logic [63:0]  bmem_wdata;
  logic         bmem_ready;
  logic [31:0]  bmem_raddr;
  logic [63:0]  bmem_rdata;
  logic         bmem_rvalid;
  logic         proto_err;

  always #5 clk = ~clk;

  dfp_burst_adapter dut (
    .clk(clk), .rst_n(rst_n),
    .dfp_addr(dfp_addr), .dfp_read(dfp_read), .dfp_write(dfp_write),
    .dfp_wdata(dfp_wdata), .dfp_rdata(dfp_rdata), .dfp_resp(dfp_resp),
    .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
    .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr),
    .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid), .proto_err(proto_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_vec(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // stimulus knobs shared by the transaction runner
  bit           ready_pat[MAXC];
  int           gaps[4];
  logic [255:0] rline;
  bit           noise;
  int           drop_c;

  // observations of the last transaction
  int           resp_cyc[$];
  logic [255:0] resp_rdata[$];
  logic [63:0]  wr_q[$];
  int           rd_cmds, cmd_c, addr_err, hold_err;
  logic [255:0] last_line;

  function automatic int model_resp(input bit wr);
    int n = 0;
    for (int c = 1; c < MAXC; c++) begin
      if (ready_pat[c]) begin
        if (!wr) return c + gaps[0] + gaps[1] + gaps[2] + gaps[3] + 3 + 1;
        n++;
        if (n == 4) return c + 1;
      end
    end
    return -1;
  endfunction

  task automatic fill_ready(input int mode);
    for (int c = 0; c < MAXC; c++) begin
      case (mode)
        1:       ready_pat[c] = !(c >= 2 && c <= 4);
        2:       ready_pat[c] = !(c >= 1 && c <= 3);
        3:       ready_pat[c] = ($urandom_range(0, 9) < 7);
        default: ready_pat[c] = 1'b1;
      endcase
    end
  endtask

  // Runs one transaction starting at the current negedge (cycle 0 = request visible in IDLE)
  task automatic run_txn(input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [255:0] wdata, input logic [31:0] exp_baddr);
    int          bt[4];
    int          done_c, nneed;
    bit          stalled, beat_now, noise_ok;
    logic [63:0] held_d;
    resp_cyc.delete(); resp_rdata.delete(); wr_q.delete();
    rd_cmds = 0; cmd_c = -1; addr_err = 0; hold_err = 0;
    bt = '{-1, -1, -1, -1};
    done_c = -1; stalled = 1'b0; held_d = '0;
    nneed = (rd && wr) ? 2 : 1;
    dfp_addr = addr; dfp_read = rd; dfp_write = wr; dfp_wdata = wdata;
    for (int c = 0; c < MAXC; c++) begin
      if (dfp_resp) begin
        resp_cyc.push_back(c);
        resp_rdata.push_back(dfp_rdata);
      end
      if ((bmem_read || bmem_write) && bmem_addr !== exp_baddr) addr_err++;
      if (stalled && (!bmem_write || bmem_wdata !== held_d)) hold_err++;
      bmem_ready = ready_pat[c];
      if (bmem_write) begin
        stalled = !bmem_ready;
        held_d  = bmem_wdata;
        if (bmem_ready) wr_q.push_back(bmem_wdata);
      end else begin
        stalled = 1'b0;
      end
      if (bmem_read && bmem_ready) begin
        rd_cmds++;
        if (cmd_c < 0) begin
          cmd_c = c;
          bt[0] = c + gaps[0];
          for (int i = 1; i < 4; i++) bt[i] = bt[i-1] + gaps[i] + 1;
        end
      end
      beat_now    = 1'b0;
      bmem_rvalid = 1'b0;
      bmem_raddr  = exp_baddr;
      bmem_rdata  = {$urandom(), $urandom()};
      for (int i = 0; i < 4; i++) begin
        if (c == bt[i]) begin
          beat_now    = 1'b1;
          bmem_rvalid = 1'b1;
          bmem_rdata  = rline[64*i +: 64];
        end
      end
      noise_ok = (c == 0) || (wr && !rd) || (rd && !wr && (cmd_c < 0 || c == cmd_c));
      if (!beat_now && noise && noise_ok) bmem_rvalid = ($urandom_range(0, 1) == 1);
      if (c == drop_c) begin
        dfp_read = 1'b0; dfp_write = 1'b0;
      end
      if (dfp_resp) begin
        if (dfp_read && dfp_write) dfp_write = 1'b0;
        else begin
          dfp_read = 1'b0; dfp_write = 1'b0;
        end
        if (done_c < 0 && resp_cyc.size() >= nneed) done_c = c;
      end
      if (done_c >= 0 && c >= done_c + 2) break;
      @(negedge clk);
    end
    bmem_rvalid = 1'b0;
    dfp_read = 1'b0; dfp_write = 1'b0;
    if (done_c < 0) begin
      n_checks++; n_fail++;
      $display("FAIL txn_timeout: got no completion within %0d cycles expected dfp_resp", MAXC);
    end
  endtask

  task automatic check_txn(input string tag, input bit rd, input bit wr,
                           input logic [255:0] data, input int exp_resp);
    logic [255:0] got;
    check_int({tag, "_nresp"}, resp_cyc.size(), 1);
    check_int({tag, "_resp_cycle"}, (resp_cyc.size() > 0) ? resp_cyc[0] : -1, exp_resp);
    got = (resp_rdata.size() > 0) ? resp_rdata[0] : 'x;
    check_vec({tag, "_rdata"}, got, rd ? data : last_line);
    if (rd) last_line = data;
    check_vec({tag, "_rdata_hold"}, dfp_rdata, last_line);
    check_int({tag, "_nbeats"}, wr_q.size(), wr ? 4 : 0);
    if (wr) begin
      got = 'x;
      if (wr_q.size() == 4) for (int i = 0; i < 4; i++) got[64*i +: 64] = wr_q[i];
      check_vec({tag, "_wbeats"}, got, data);
    end
    check_int({tag, "_ncmd"}, rd_cmds, rd ? 1 : 0);
    check_int({tag, "_addr_err"}, addr_err, 0);
    check_int({tag, "_hold_err"}, hold_err, 0);
  endtask

  typedef struct {
    bit           rd;
    bit           wr;
    logic [31:0]  addr;
    logic [255:0] data;
    int           g0, g1, g2, g3;
    int           mode;
    int           drop;
    int           exp_resp;
    logic [31:0]  exp_baddr;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [255:0] d;
    logic [31:0]  a;
    bit           r;
    vecs[0] = '{1, 0, 32'h1000_0024,
                {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
                3, 0, 0, 0, 0, -1, 8, 32'h1000_0020};
    vecs[1] = '{0, 1, 32'h0000_0040,
                {64'hD3D3_0000_0000_0003, 64'hD2D2_0000_0000_0002,
                 64'hD1D1_0000_0000_0001, 64'hD0D0_0000_0000_0000},
                1, 0, 0, 0, 0, -1, 5, 32'h0000_0040};
    vecs[2] = '{0, 1, 32'h1234_5678,
                {64'hAAAA_BBBB_CCCC_0003, 64'hAAAA_BBBB_CCCC_0002,
                 64'hAAAA_BBBB_CCCC_0001, 64'hAAAA_BBBB_CCCC_0000},
                1, 0, 0, 0, 1, -1, 8, 32'h1234_5660};
    vecs[3] = '{1, 0, 32'hABCD_EF1F,
                {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                 64'h5A5A_5A5A_A5A5_A5A5, 64'hDEAD_BEEF_CAFE_F00D},
                1, 0, 2, 5, 0, -1, 13, 32'hABCD_EF00};
    vecs[4] = '{1, 0, 32'h0000_1FE0,
                {64'h1, 64'h2, 64'h3, 64'h4}, 1, 0, 0, 0, 2, -1, 9, 32'h0000_1FE0};
    vecs[5] = '{0, 1, 32'h8000_0000,
                {64'hF0F0, 64'h0F0F, 64'hFFFF_0000, 64'h0000_FFFF}, 1, 0, 0, 0, 0, 2, 5,
                32'h8000_0000};
    vecs[6] = '{1, 0, 32'hFFFF_FFFF,
                {64'h9, 64'h8, 64'h7, 64'h6}, 2, 0, 0, 0, 0, 3, 7, 32'hFFFF_FFE0};

    rst_n = 1'b0;
    dfp_addr = '0; dfp_read = 1'b0; dfp_write = 1'b0; dfp_wdata = '0;
    bmem_ready = 1'b0; bmem_raddr = '0; bmem_rdata = '0; bmem_rvalid = 1'b0;
    noise = 1'b0; drop_c = -1; last_line = '0;
    gaps = '{1, 0, 0, 0}; rline = '0;
    repeat (2) @(negedge clk);
    check_vec("reset_outputs",
              {dfp_rdata[31:0], bmem_addr, bmem_wdata, 27'd0, dfp_resp, bmem_read, bmem_write,
               proto_err, 1'b0},
              '0);
    check_vec("reset_rdata", dfp_rdata, '0);
    rst_n = 1'b1;
    @(negedge clk);
    check_int("idle_after_reset", {29'd0, dfp_resp, bmem_read, bmem_write}, 0);

`ifdef PROTOCOL_CHECK_EN
    bmem_rvalid = 1'b1;
    @(negedge clk);
    bmem_rvalid = 1'b0;
    check_int("proto_err_set", int'(proto_err), 1);
    repeat (3) @(negedge clk);
    check_int("proto_err_sticky", int'(proto_err), 1);
    rst_n = 1'b0;
    #1;
    check_int("proto_err_reset", int'(proto_err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
`endif

    // directed vector table
    for (int i = 0; i < 7; i++) begin
      gaps   = '{vecs[i].g0, vecs[i].g1, vecs[i].g2, vecs[i].g3};
      rline  = vecs[i].data;
      noise  = 1'b1;
      drop_c = vecs[i].drop;
      fill_ready(vecs[i].mode);
      run_txn(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].exp_baddr);
      check_txn($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].data, vecs[i].exp_resp);
    end
    drop_c = -1;

    // read and write requested together: write burst first, then the read
    noise = 1'b0;
    fill_ready(0);
    gaps  = '{1, 0, 0, 0};
    rline = {64'hCC03, 64'hCC02, 64'hCC01, 64'hCC00};
    d     = {64'hEE03, 64'hEE02, 64'hEE01, 64'hEE00};
    run_txn(1'b1, 1'b1, 32'h0000_2000, d, 32'h0000_2000);
    check_int("both_nresp", resp_cyc.size(), 2);
    check_int("both_wr_resp", (resp_cyc.size() > 0) ? resp_cyc[0] : -1, 5);
    check_int("both_rd_resp", (resp_cyc.size() > 1) ? resp_cyc[1] : -1, 12);
    check_int("both_cmd_after_wr", cmd_c, 7);
    check_int("both_nbeats", wr_q.size(), 4);
    check_vec("both_rdata", (resp_rdata.size() > 1) ? resp_rdata[1] : 'x, rline);
    last_line = rline;

    // reset in the middle of a write burst
    dfp_addr = 32'h0000_3000; dfp_wdata = d; dfp_write = 1'b1; bmem_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_int("pre_reset_busy", int'(bmem_write), 1);
    rst_n = 1'b0; dfp_write = 1'b0;
    #1;
    check_vec("midburst_reset_outputs",
              {bmem_addr, bmem_wdata, 29'd0, dfp_resp, bmem_write, bmem_read}, '0);
    check_vec("midburst_reset_rdata", dfp_rdata, '0);
    last_line = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // randomized transactions against the transaction-level model
    for (int t = 0; t < 30; t++) begin
      r = ($urandom_range(0, 1) == 1);
      a = $urandom();
      for (int i = 0; i < 8; i++) d[32*i +: 32] = $urandom();
      gaps  = '{$urandom_range(1, 4), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3)};
      rline = d;
      noise = ($urandom_range(0, 1) == 1);
      fill_ready(3);
      run_txn(r, !r, a, d, a & ~32'h1F);
      check_txn($sformatf("rnd%0d", t), r, !r, d, model_resp(!r));
    end

`ifndef PROTOCOL_CHECK_EN
    check_int("proto_err_tied", int'(proto_err), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
